sqrt_iter_core: RTL and testbench



---
 rtl/sqrt_iter_core.sv | 123 ++++++++++++
 tb/tb_sqrt_iter_core.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sqrt_iter_core.sv
// Restoring digit-by-digit integer square root: resolves one root bit per clock
// and returns the floor root and remainder with a single-cycle done pulse.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; root/rem hold the previous result
// ST_RUN  | one iteration per edge, counter counts HALF down to 0
// ST_DONE | result registers loaded, done high for this one cycle
module sqrt_iter_core #(
  parameter int WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     radicand,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH/2-1:0]   root,
  output logic [WIDTH/2:0]     rem
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [HALF+1:0]   r_q, r_d;
  logic [HALF-1:0]   q_q, q_d;
  logic [HALF-1:0]   root_q, root_d;
  logic [HALF:0]     rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [HALF+1:0]   r_sh;
  logic [HALF+1:0]   t_val;
  logic [HALF+1:0]   r_sub;
  logic              r_ge;
  logic [1:0]        unused_r_hi;

  // The working remainder never exceeds 2Q, so its top two bits are always
  // zero before the shift and can be dropped.
  assign unused_r_hi = r_q[HALF+1:HALF];

  always_comb begin
    r_sh  = {r_q[HALF-1:0], sr_q[WIDTH-1:WIDTH-2]};
    t_val = {q_q, 2'b01};
    r_ge  = (r_sh >= t_val);
    r_sub = r_sh - t_val;

    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    r_d     = r_q;
    q_d     = q_q;
    root_d  = root_q;
    rem_d   = rem_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = radicand;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = CW'(HALF);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sr_d  = {sr_q[WIDTH-3:0], 2'b00};
        r_d   = r_ge ? r_sub : r_sh;
        q_d   = {q_q[HALF-2:0], r_ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          root_d  = q_d;
          rem_d   = r_d[HALF:0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      r_q     <= '0;
      q_q     <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      r_q     <= r_d;
      q_q     <= q_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign root = root_q;
  assign rem  = rem_q;

endmodule

// File: tb/tb_sqrt_iter_core.sv
// Scoreboard bench for sqrt_iter_core: stimulus pushes expected {root, rem},
// a monitor pops and compares on every done pulse.
module tb_sqrt_iter_core;

  localparam int WIDTH = 20;
  localparam int HALF  = WIDTH / 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  radicand = '0;
  logic              busy;
  logic              done;
  logic [HALF-1:0]   root;
  logic [HALF:0]     rem;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*HALF:0] exp_q[$];

  sqrt_iter_core #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .radicand (radicand),
    .busy     (busy),
    .done     (done),
    .root     (root),
    .rem      (rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [2*HALF:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no result (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("root", 32'(root), 32'(e[2*HALF:HALF+1]));
          chk("rem", 32'(rem), 32'(e[HALF:0]));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || done !== 1'b0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("idle_timeout", 32'(n), 32'(0));
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [HALF-1:0] er,
                       input logic [HALF:0] em, input bit inject);
    int n = 0;
    int busy_n;
    int acc;
    wait_idle();
    start    = 1'b1;
    radicand = a;
    exp_q.push_back({er, em});
    @(posedge clk);
    #1;
    acc    = cyc;
    busy_n = (busy === 1'b1) ? 1 : 0;
    @(negedge clk);
    start    = 1'b0;
    radicand = WIDTH'($urandom);
    if (inject) begin
      fork
        begin
          repeat (3) @(negedge clk);
          start    = 1'b1;
          radicand = WIDTH'(9);
          @(negedge clk);
          start    = 1'b0;
        end
      join_none
    end
    while (done !== 1'b1 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (busy === 1'b1) busy_n++;
    end
    chk("done_seen", 32'(done), 32'(1));
    chk("latency", 32'(cyc - acc), 32'(HALF));
    chk("busy_cycles", 32'(busy_n), 32'(HALF));
    @(posedge clk);
    #1;
    chk("done_pulse_width", 32'(done), 32'(0));
  endtask

  task automatic wait_done(output int at);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done !== 1'b1 && n < 40);
    if (n >= 40) chk("done_timeout", 32'(n), 32'(0));
    at = cyc;
  endtask

  initial begin
    int d0, d1, d2;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_root", 32'(root), 32'(0));
    chk("rst_rem", 32'(rem), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    issue(20'd2,       10'd1,    11'd1,    1'b0);
    issue(20'd524288,  10'd724,  11'd112,  1'b0);
    issue(20'd1000000, 10'd1000, 11'd0,    1'b0);
    issue(20'd0,       10'd0,    11'd0,    1'b0);
    issue(20'd1048575, 10'd1023, 11'd2046, 1'b0);
    issue(20'd16,      10'd4,    11'd0,    1'b1);
    repeat (15) @(posedge clk);

    // Continuous start: three back-to-back results.
    wait_idle();
    repeat (3) exp_q.push_back({10'd9, 11'd0});
    start    = 1'b1;
    radicand = 20'd81;
    wait_done(d0);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_root", 32'(root), 32'(9));
    chk("hold_rem", 32'(rem), 32'(0));
    chk("hold_busy", 32'(busy), 32'(1));
    wait_done(d1);
    wait_done(d2);
    @(negedge clk);
    start = 1'b0;
    chk("spacing_1", 32'(d1 - d0), 32'(HALF + 2));
    chk("spacing_2", 32'(d2 - d1), 32'(HALF + 2));

    // Abort mid-run with asynchronous reset.
    wait_idle();
    start    = 1'b1;
    radicand = 20'd1000000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_root", 32'(root), 32'(0));
    chk("abort_rem", 32'(rem), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    issue(20'd25, 10'd5, 11'd0, 1'b0);

    repeat (20) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
